// File: rtl/player_shot_ctrl.sv
// Player sprite and single-shot controller: steps player x and the shot once per frame strobe
// and sequences the shot through idle, flying and cooldown.
module player_shot_ctrl #(
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned PLAYER_W        = 16,
    parameter int unsigned PLAYER_Y        = 400,
    parameter int unsigned PLAYER_X_INIT   = 312,
    parameter int unsigned PLAYER_SPEED    = 2,
    parameter int unsigned SHOT_SPEED      = 4,
    parameter int unsigned SHOT_TOP        = 16,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       frame_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       shoot_i,
    input  logic       hit_i,
    output logic [9:0] player_x_o,
    output logic       shot_active_o,
    output logic [9:0] shot_x_o,
    output logic [9:0] shot_y_o,
    output logic [1:0] state_o
);

    localparam int unsigned CntW = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [9:0]      XMax     = 10'(SCREEN_W - PLAYER_W);
    localparam logic [9:0]      XInit    = 10'(PLAYER_X_INIT);
    localparam logic [9:0]      Speed    = 10'(PLAYER_SPEED);
    localparam logic [9:0]      ShotOfs  = 10'(PLAYER_W / 2 - 1);
    localparam logic [9:0]      SpawnY   = 10'(PLAYER_Y);
    localparam logic [9:0]      ShotStep = 10'(SHOT_SPEED);
    localparam logic [9:0]      ShotMin  = 10'(SHOT_TOP + SHOT_SPEED);
    localparam logic [CntW-1:0] CntInit  = CntW'(COOLDOWN_FRAMES);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StFlying   = 2'd1,
        StCooldown = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      player_x_q, player_x_d;
    logic [9:0]      shot_x_q, shot_x_d;
    logic [9:0]      shot_y_q, shot_y_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fire_pending_q, fire_pending_d;
    logic            shoot_prev_q;
    logic            fire;

    // An edge arriving in the frame cycle itself still counts for that frame.
    assign fire           = fire_pending_q | (shoot_i & ~shoot_prev_q);
    assign fire_pending_d = frame_i ? 1'b0 : fire;

    always_comb begin
        player_x_d = player_x_q;
        if (frame_i) begin
            if (right_i && !left_i) begin
                player_x_d = (player_x_q > XMax - Speed) ? XMax : player_x_q + Speed;
            end else if (left_i && !right_i) begin
                player_x_d = (player_x_q < Speed) ? 10'd0 : player_x_q - Speed;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;
        cnt_d    = cnt_q;
        if (state_q == StFlying && hit_i) begin
            state_d = StCooldown;
            cnt_d   = CntInit;
        end else if (frame_i) begin
            unique case (state_q)
                StIdle: begin
                    if (fire) begin
                        state_d  = StFlying;
                        shot_x_d = player_x_q + ShotOfs;
                        shot_y_d = SpawnY;
                    end
                end
                StFlying: begin
                    if (shot_y_q < ShotMin) begin
                        state_d = StCooldown;
                        cnt_d   = CntInit;
                    end else begin
                        shot_y_d = shot_y_q - ShotStep;
                    end
                end
                StCooldown: begin
                    if (cnt_q == CntOne) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q        <= StIdle;
            player_x_q     <= XInit;
            shot_x_q       <= '0;
            shot_y_q       <= '0;
            cnt_q          <= '0;
            fire_pending_q <= 1'b0;
            shoot_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_x_q     <= player_x_d;
            shot_x_q       <= shot_x_d;
            shot_y_q       <= shot_y_d;
            cnt_q          <= cnt_d;
            fire_pending_q <= fire_pending_d;
            shoot_prev_q   <= shoot_i;
        end
    end

    assign player_x_o    = player_x_q;
    assign shot_active_o = (state_q == StFlying);
    assign shot_x_o      = shot_x_q;
    assign shot_y_o      = shot_y_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Directed bench for player_shot_ctrl: a behavioural model pushes expected outputs into a
// scoreboard each cycle, popped and compared after the clock edge.
module tb_player_shot_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, frame, left, right, shoot, hit;
    logic [9:0] player_x, shot_x, shot_y;
    logic       shot_active;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int launches = 0;

    typedef struct {
        int x;
        int act;
        int sx;
        int sy;
        int st;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int m_x = 312, m_sx = 0, m_sy = 0, m_st = 0, m_cnt = 0;
    bit m_pend = 0, m_prev = 0;

    always #5 clk = ~clk;

    player_shot_ctrl dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .frame_i       (frame),
        .left_i        (left),
        .right_i       (right),
        .shoot_i       (shoot),
        .hit_i         (hit),
        .player_x_o    (player_x),
        .shot_active_o (shot_active),
        .shot_x_o      (shot_x),
        .shot_y_o      (shot_y),
        .state_o       (state)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit fr, input bit l, input bit r, input bit s, input bit h,
                         input bit rn);
        bit fire;
        int old_x;
        if (!rn) begin
            m_x = 312; m_sx = 0; m_sy = 0; m_st = 0; m_cnt = 0; m_pend = 0; m_prev = 0;
            return;
        end
        fire   = m_pend || (s && !m_prev);
        m_prev = s;
        m_pend = fr ? 1'b0 : fire;
        old_x  = m_x;
        if (fr) begin
            if (r && !l) m_x = (m_x + 2 > 624) ? 624 : m_x + 2;
            else if (l && !r) m_x = (m_x < 2) ? 0 : m_x - 2;
        end
        if (m_st == 1 && h) begin
            m_st = 2; m_cnt = 8;
        end else if (fr) begin
            case (m_st)
                0: if (fire) begin m_st = 1; m_sx = old_x + 7; m_sy = 400; end
                1: if (m_sy < 20) begin m_st = 2; m_cnt = 8; end else m_sy -= 4;
                default: if (m_cnt == 1) begin m_st = 0; m_cnt = 0; end else m_cnt--;
            endcase
        end
    endtask

    task automatic cyc(input bit fr, input bit l, input bit r, input bit s, input bit h,
                       input bit rn);
        exp_t e, o;
        int   prev_st;
        prev_st = int'(state);
        frame = fr; left = l; right = r; shoot = s; hit = h; reset_n = rn;
        model(fr, l, r, s, h, rn);
        e = '{x: m_x, act: (m_st == 1) ? 1 : 0, sx: m_sx, sy: m_sy, st: m_st};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("player_x", int'(player_x), o.x);
        check("shot_active", int'(shot_active), o.act);
        check("shot_x", int'(shot_x), o.sx);
        check("shot_y", int'(shot_y), o.sy);
        check("state", int'(state), o.st);
        if (rn && prev_st != 1 && state == 2'd1) launches++;
    endtask

    // One idle cycle then one frame-strobe cycle, buttons held across both
    task automatic frames(input int n, input bit l, input bit r, input bit s);
        for (int i = 0; i < n; i++) begin
            cyc(0, l, r, s, 0, 1);
            cyc(1, l, r, s, 0, 1);
        end
    endtask

    initial begin
        frame = 0; left = 0; right = 0; shoot = 0; hit = 0; reset_n = 0;
        #2;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_x", int'(player_x), 312);
        check("rst_state", int'(state), 0);
        check("rst_active", int'(shot_active), 0);

        frames(3, 0, 1, 0);
        check("right3", int'(player_x), 318);
        frames(2, 1, 1, 0);
        check("both2", int'(player_x), 318);
        frames(200, 0, 1, 0);
        check("sat_right", int'(player_x), 624);
        frames(400, 1, 0, 0);
        check("sat_left", int'(player_x), 0);

        cyc(0, 0, 0, 0, 0, 0);
        frames(1, 0, 0, 0);
        check("x_after_rst", int'(player_x), 312);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check("launch_state", int'(state), 1);
        check("launch_sx", int'(shot_x), 319);
        check("launch_sy", int'(shot_y), 400);
        check("launch_act", int'(shot_active), 1);
        frames(96, 0, 0, 0);
        check("f96_sy", int'(shot_y), 16);
        check("f96_state", int'(state), 1);
        frames(1, 0, 0, 0);
        check("f97_state", int'(state), 2);
        check("f97_act", int'(shot_active), 0);
        frames(7, 0, 0, 0);
        check("f104_state", int'(state), 2);
        frames(1, 0, 0, 0);
        check("f105_state", int'(state), 0);

        // Hit together with frame mid-flight; a press during cooldown is dropped
        cyc(0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        frames(5, 0, 0, 0);
        check("pre_hit_sy", int'(shot_y), 380);
        cyc(1, 0, 0, 0, 1, 1);
        check("hit_state", int'(state), 2);
        check("hit_sy", int'(shot_y), 380);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        frames(8, 0, 0, 0);
        check("cd_idle", int'(state), 0);
        frames(1, 0, 0, 0);
        check("cd_no_fire", int'(state), 0);

        // Held shoot launches exactly once
        launches = 0;
        frames(150, 0, 0, 1);
        check("hold_launches", launches, 1);
        check("hold_idle", int'(state), 0);
        frames(1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1);
        check("repress_state", int'(state), 1);

        // Reset mid-flight at x=500 discards a pending fire
        frames(94, 0, 1, 0);
        check("x500", int'(player_x), 500);
        check("x500_state", int'(state), 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("mid_rst_x", int'(player_x), 312);
        check("mid_rst_state", int'(state), 0);
        check("mid_rst_act", int'(shot_active), 0);
        cyc(1, 0, 0, 0, 0, 1);
        check("pend_discard", int'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
